// File: rtl/apb_vgachargen_bridge.sv
// APB3/APB4 completer for the vgachargen char map, colour map and font memories.
// Registered address/data/strobes, single-cycle write pulse, fixed 1-cycle read latency.
module apb_vgachargen_bridge #(
    parameter int unsigned MAP_WORDS       = 600,
    parameter int unsigned CH_T_ADDR_WIDTH = 10,
    parameter int unsigned CH_T_DATA_WIDTH = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       psel_i,
    input  logic                       penable_i,
    input  logic                       pwrite_i,
    input  logic [31:0]                paddr_i,
    input  logic [31:0]                pwdata_i,
    input  logic [3:0]                 pstrb_i,
    output logic                       pready_o,
    output logic [31:0]                prdata_o,
    output logic                       pslverr_o,
    output logic [9:0]                 char_map_addr_o,
    output logic                       char_map_we_o,
    output logic [3:0]                 char_map_be_o,
    output logic [31:0]                char_map_wdata_o,
    input  logic [31:0]                char_map_rdata_i,
    output logic [9:0]                 col_map_addr_o,
    output logic                       col_map_we_o,
    output logic [3:0]                 col_map_be_o,
    output logic [31:0]                col_map_wdata_o,
    input  logic [31:0]                col_map_rdata_i,
    output logic [CH_T_ADDR_WIDTH-1:0] char_tiff_addr_o,
    output logic                       char_tiff_we_o,
    output logic [CH_T_DATA_WIDTH-1:0] char_tiff_wdata_o,
    input  logic [CH_T_DATA_WIDTH-1:0] char_tiff_rdata_i
);

    localparam int unsigned FONT_WORDS = 1 << CH_T_ADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        WR_ACC,
        RD_WAIT,
        RD_ACC,
        ERR_ACC
    } state_t;

    typedef enum logic [1:0] {
        RGN_CHAR,
        RGN_COL,
        RGN_FONT,
        RGN_NONE
    } region_t;

    state_t  state_q, state_d;
    region_t rgn_q, dec_rgn;

    logic       setup;
    logic       dec_err;
    logic [9:0] map_idx;
    logic [10:0] font_off;

    logic [9:0]                 char_addr_q, col_addr_q;
    logic [3:0]                 char_be_q, col_be_q;
    logic [31:0]                char_wdata_q, col_wdata_q;
    logic [CH_T_ADDR_WIDTH-1:0] font_addr_q;
    logic [CH_T_DATA_WIDTH-1:0] font_wdata_q;

    assign setup    = psel_i & ~penable_i;
    assign map_idx  = paddr_i[11:2];
    // Font region spans 0x2000-0x3FFF; bound-check the word offset within it.
    assign font_off = paddr_i[12:2];

    always_comb begin
        dec_rgn = RGN_NONE;
        if (paddr_i[31:14] == '0) begin
            case (paddr_i[13:12])
                2'b00:   dec_rgn = RGN_CHAR;
                2'b01:   dec_rgn = RGN_COL;
                default: dec_rgn = RGN_FONT;
            endcase
        end
    end

    always_comb begin
        dec_err = 1'b0;
        if (paddr_i[1:0] != 2'b00) begin
            dec_err = 1'b1;
        end
        case (dec_rgn)
            RGN_CHAR, RGN_COL: begin
                if (32'(map_idx) >= MAP_WORDS) dec_err = 1'b1;
            end
            RGN_FONT: begin
                if (32'(font_off) >= FONT_WORDS) dec_err = 1'b1;
                if (pwrite_i && (pstrb_i != 4'hF)) dec_err = 1'b1;
            end
            default: dec_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            rgn_q   <= RGN_NONE;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && setup) begin
                rgn_q <= dec_rgn;
            end
        end
    end

    // Only the selected region's registers move; the others keep their last value.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            char_addr_q  <= '0;
            char_be_q    <= '0;
            char_wdata_q <= '0;
            col_addr_q   <= '0;
            col_be_q     <= '0;
            col_wdata_q  <= '0;
            font_addr_q  <= '0;
            font_wdata_q <= '0;
        end else if ((state_q == IDLE) && setup && !dec_err) begin
            case (dec_rgn)
                RGN_CHAR: begin
                    char_addr_q <= map_idx;
                    if (pwrite_i) begin
                        char_be_q    <= pstrb_i;
                        char_wdata_q <= pwdata_i;
                    end
                end
                RGN_COL: begin
                    col_addr_q <= map_idx;
                    if (pwrite_i) begin
                        col_be_q    <= pstrb_i;
                        col_wdata_q <= pwdata_i;
                    end
                end
                RGN_FONT: begin
                    font_addr_q <= paddr_i[CH_T_ADDR_WIDTH+1:2];
                    if (pwrite_i) begin
                        font_wdata_q <= pwdata_i[CH_T_DATA_WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d        = state_q;
        pready_o       = 1'b0;
        pslverr_o      = 1'b0;
        prdata_o       = '0;
        char_map_we_o  = 1'b0;
        col_map_we_o   = 1'b0;
        char_tiff_we_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (setup) begin
                    if (dec_err)       state_d = ERR_ACC;
                    else if (pwrite_i) state_d = WR_ACC;
                    else               state_d = RD_WAIT;
                end
            end
            WR_ACC: begin
                pready_o       = 1'b1;
                char_map_we_o  = (rgn_q == RGN_CHAR);
                col_map_we_o   = (rgn_q == RGN_COL);
                char_tiff_we_o = (rgn_q == RGN_FONT);
                state_d        = IDLE;
            end
            RD_WAIT: begin
                state_d = psel_i ? RD_ACC : IDLE;
            end
            RD_ACC: begin
                if (psel_i) begin
                    pready_o = 1'b1;
                    case (rgn_q)
                        RGN_CHAR: prdata_o = char_map_rdata_i;
                        RGN_COL:  prdata_o = col_map_rdata_i;
                        RGN_FONT: prdata_o = 32'(char_tiff_rdata_i);
                        default:  prdata_o = '0;
                    endcase
                end
                state_d = IDLE;
            end
            ERR_ACC: begin
                pready_o  = 1'b1;
                pslverr_o = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign char_map_addr_o   = char_addr_q;
    assign char_map_be_o     = char_be_q;
    assign char_map_wdata_o  = char_wdata_q;
    assign col_map_addr_o    = col_addr_q;
    assign col_map_be_o      = col_be_q;
    assign col_map_wdata_o   = col_wdata_q;
    assign char_tiff_addr_o  = font_addr_q;
    assign char_tiff_wdata_o = font_wdata_q;

endmodule

// File: tb/tb_apb_vgachargen_bridge.sv
// Directed bench for apb_vgachargen_bridge with behavioural sync-RAM models.
module tb_apb_vgachargen_bridge;

    logic        clk, rst_n;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic        pready, pslverr;
    logic [31:0] prdata;
    logic [9:0]  char_addr, col_addr, tiff_addr;
    logic        char_we, col_we, tiff_we;
    logic [3:0]  char_be, col_be;
    logic [31:0] char_wdata, col_wdata, tiff_wdata;
    logic [31:0] char_rdata, col_rdata, tiff_rdata;

    apb_vgachargen_bridge #(
        .MAP_WORDS(600),
        .CH_T_ADDR_WIDTH(10),
        .CH_T_DATA_WIDTH(32)
    ) dut (
        .clk_i(clk), .rst_i(rst_n),
        .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
        .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
        .pready_o(pready), .prdata_o(prdata), .pslverr_o(pslverr),
        .char_map_addr_o(char_addr), .char_map_we_o(char_we), .char_map_be_o(char_be),
        .char_map_wdata_o(char_wdata), .char_map_rdata_i(char_rdata),
        .col_map_addr_o(col_addr), .col_map_we_o(col_we), .col_map_be_o(col_be),
        .col_map_wdata_o(col_wdata), .col_map_rdata_i(col_rdata),
        .char_tiff_addr_o(tiff_addr), .char_tiff_we_o(tiff_we),
        .char_tiff_wdata_o(tiff_wdata), .char_tiff_rdata_i(tiff_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] char_mem [0:1023];
    logic [31:0] col_mem  [0:1023];
    logic [31:0] font_mem [0:1023];
    logic        mem_init;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) begin
                char_mem[i] <= 32'h0;
                col_mem[i]  <= 32'h0;
                font_mem[i] <= 32'h0;
            end
            col_mem[0] <= 32'h0BADC0DE;
            col_mem[1] <= 32'h55667788;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (char_we && char_be[b]) char_mem[char_addr][8*b +: 8] <= char_wdata[8*b +: 8];
                if (col_we && col_be[b])   col_mem[col_addr][8*b +: 8]   <= col_wdata[8*b +: 8];
            end
            if (tiff_we) font_mem[tiff_addr] <= tiff_wdata;
        end
        char_rdata <= char_mem[char_addr];
        col_rdata  <= col_mem[col_addr];
        tiff_rdata <= font_mem[tiff_addr];
    end

    int          char_cnt, col_cnt, font_cnt;
    logic [9:0]  char_last_addr, col_last_addr, font_last_addr;
    logic [3:0]  char_last_be, col_last_be;

    initial begin
        char_cnt = 0; col_cnt = 0; font_cnt = 0;
        char_last_addr = '0; col_last_addr = '0; font_last_addr = '0;
        char_last_be = '0; col_last_be = '0;
    end

    always @(negedge clk) begin
        if (char_we) begin char_cnt++; char_last_addr = char_addr; char_last_be = char_be; end
        if (col_we)  begin col_cnt++;  col_last_addr = col_addr;   col_last_be = col_be;   end
        if (tiff_we) begin font_cnt++; font_last_addr = tiff_addr; end
    end

    int n_pass, n_total;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_pready"}, 64'(pready), 64'd0);
        chk({tag, "_prdata"}, 64'(prdata), 64'd0);
        chk({tag, "_pslverr"}, 64'(pslverr), 64'd0);
        chk({tag, "_we"}, 64'({char_we, col_we, tiff_we}), 64'd0);
        chk({tag, "_char"}, 64'({char_addr, char_be, char_wdata}), 64'd0);
        chk({tag, "_col"}, 64'({col_addr, col_be, col_wdata}), 64'd0);
        chk({tag, "_tiff"}, 64'({tiff_addr, tiff_wdata}), 64'd0);
    endtask

    // Starts at posedge+1; returns at posedge+1 after the ready cycle with psel still high.
    task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output logic err,
                        output int cyc);
        bit done;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        @(posedge clk); #1;
        penable = 1'b1;
        cyc = 0; done = 1'b0; rd = '0; err = 1'b0;
        while (!done && cyc < 8) begin
            cyc++;
            @(negedge clk);
            if (pready === 1'b1) begin
                rd = prdata; err = pslverr; done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            cyc = 99; psel = 1'b0; penable = 1'b0;
        end
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_rd;
        bit          exp_err;
        int          exp_cyc;
        int          exp_rgn;
        logic [9:0]  exp_maddr;
        logic [3:0]  exp_be;
    } vec_t;

    localparam int N = 16;
    vec_t vecs [N];

    logic [31:0] rd;
    logic        err;
    int          cyc, c0, c1, c2;

    initial begin
        n_pass = 0; n_total = 0;
        vecs[0]  = '{1'b1, 32'h0008, 32'hA5A5A5A5, 4'hF, 32'h0,        1'b0, 1, 1, 10'd2,   4'hF};
        vecs[1]  = '{1'b0, 32'h0008, 32'h0,        4'h0, 32'hA5A5A5A5, 1'b0, 2, 0, 10'd0,   4'h0};
        vecs[2]  = '{1'b1, 32'h1004, 32'h00000011, 4'h1, 32'h0,        1'b0, 1, 2, 10'd1,   4'h1};
        vecs[3]  = '{1'b0, 32'h1004, 32'h0,        4'h0, 32'h55667711, 1'b0, 2, 0, 10'd0,   4'h0};
        vecs[4]  = '{1'b1, 32'h2000, 32'h12345678, 4'h3, 32'h0,        1'b1, 1, 0, 10'd0,   4'h0};
        vecs[5]  = '{1'b0, 32'h0960, 32'h0,        4'h0, 32'h0,        1'b1, 1, 0, 10'd0,   4'h0};
        vecs[6]  = '{1'b0, 32'h4000, 32'h0,        4'h0, 32'h0,        1'b1, 1, 0, 10'd0,   4'h0};
        vecs[7]  = '{1'b1, 32'h0002, 32'h11111111, 4'hF, 32'h0,        1'b1, 1, 0, 10'd0,   4'h0};
        vecs[8]  = '{1'b1, 32'h3000, 32'h22222222, 4'hF, 32'h0,        1'b1, 1, 0, 10'd0,   4'h0};
        vecs[9]  = '{1'b1, 32'h0000, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 1, 1, 10'd0,   4'hF};
        vecs[10] = '{1'b0, 32'h0000, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 2, 0, 10'd0,   4'h0};
        vecs[11] = '{1'b1, 32'h095C, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0, 1, 1, 10'd599, 4'hF};
        vecs[12] = '{1'b0, 32'h095C, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0, 2, 0, 10'd0,   4'h0};
        vecs[13] = '{1'b1, 32'h2FFC, 32'h0000ABCD, 4'hF, 32'h0,        1'b0, 1, 3, 10'd1023, 4'h0};
        vecs[14] = '{1'b0, 32'h2FFC, 32'h0,        4'h0, 32'h0000ABCD, 1'b0, 2, 0, 10'd0,   4'h0};
        vecs[15] = '{1'b0, 32'h1000, 32'h0,        4'h0, 32'h0BADC0DE, 1'b0, 2, 0, 10'd0,   4'h0};

        rst_n = 1'b0; mem_init = 1'b1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        repeat (3) @(posedge clk);
        #1;
        mem_init = 1'b0;
        check_all_zero("por");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Vectors run back-to-back: each setup follows the previous ready cycle directly.
        for (int i = 0; i < N; i++) begin
            c0 = char_cnt; c1 = col_cnt; c2 = font_cnt;
            xfer(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb, rd, err, cyc);
            chk($sformatf("v%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rd));
            chk($sformatf("v%0d_pslverr", i), 64'(err), 64'(vecs[i].exp_err));
            chk($sformatf("v%0d_cycles", i), 64'(cyc), 64'(vecs[i].exp_cyc));
            chk($sformatf("v%0d_char_we", i), 64'(char_cnt - c0), (vecs[i].exp_rgn == 1) ? 64'd1 : 64'd0);
            chk($sformatf("v%0d_col_we", i), 64'(col_cnt - c1), (vecs[i].exp_rgn == 2) ? 64'd1 : 64'd0);
            chk($sformatf("v%0d_font_we", i), 64'(font_cnt - c2), (vecs[i].exp_rgn == 3) ? 64'd1 : 64'd0);
            if (vecs[i].exp_rgn == 1) begin
                chk($sformatf("v%0d_char_addr", i), 64'(char_last_addr), 64'(vecs[i].exp_maddr));
                chk($sformatf("v%0d_char_be", i), 64'(char_last_be), 64'(vecs[i].exp_be));
            end
            if (vecs[i].exp_rgn == 2) begin
                chk($sformatf("v%0d_col_addr", i), 64'(col_last_addr), 64'(vecs[i].exp_maddr));
                chk($sformatf("v%0d_col_be", i), 64'(col_last_be), 64'(vecs[i].exp_be));
            end
            if (vecs[i].exp_rgn == 3) begin
                chk($sformatf("v%0d_font_addr", i), 64'(font_last_addr), 64'(vecs[i].exp_maddr));
            end
        end

        for (int i = 0; i < 256; i++) begin
            xfer(1'b1, 32'h2000 + 32'(4 * i), 32'(i), 4'hF, rd, err, cyc);
            chk($sformatf("font_wr%0d_err", i), 64'(err), 64'd0);
        end
        for (int i = 0; i < 256; i++) begin
            xfer(1'b0, 32'h2000 + 32'(4 * i), 32'h0, 4'h0, rd, err, cyc);
            chk($sformatf("font_rd%0d", i), 64'(rd), 64'(i));
        end

        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0008;
        @(posedge clk); #1;
        penable = 1'b1;
        chk("rdwait_addr", 64'(char_addr), 64'd2);
        chk("rdwait_pready", 64'(pready), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(1'b0, 32'h0008, 32'h0, 4'h0, rd, err, cyc);
        chk("postrst_rdata", 64'(rd), 64'hA5A5A5A5);
        chk("postrst_pslverr", 64'(err), 64'd0);
        chk("postrst_cycles", 64'(cyc), 64'd2);
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
